// File: rtl/test_value_tracer.sv
// test_value_tracer
//   Watches the MIPS core's Test_Value output and records every change of value
//   in a small first-word-fall-through trace FIFO. A debug host drains the FIFO
//   through a valid/ready interface.
//
//   Ports
//     CLK         system clock, rising edge
//     RST         asynchronous active-high reset
//     Test_Value  traced value, sampled every rising edge
//     Capture_En  1 = tracing active, 0 = no pushes
//     Clear       synchronous flush: empty FIFO, clear Overflow, re-arm
//     Out_Data    head-of-FIFO entry (0 when empty)
//     Out_Valid   FIFO non-empty
//     Out_Ready   consumer takes the head when Out_Valid & Out_Ready
//     Count       entries held, 0..DEPTH
//     Overflow    sticky: a capture was dropped because the FIFO was full
//     Out_Stamp   (TRACE_TIMESTAMP_EN only) cycle stamp of the head entry
//
//   Build option
//     TRACE_TIMESTAMP_EN  adds a free-running 16-bit cycle counter whose value
//                         at push time travels with each entry as Out_Stamp.

module test_value_tracer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Test_Value,
    input  logic              Capture_En,
    input  logic              Clear,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [15:0]       Out_Stamp
`endif
);

    localparam logic [ADDR_W:0] CntFull = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        StArmed,
        StRun
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   prev_q;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic full, empty, push_req, pop, push_ok;

    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);

    // ARMED captures the first enabled sample unconditionally; RUN only on change.
    assign push_req = Capture_En & ((state_q == StArmed) | (Test_Value != prev_q));
    assign pop      = ~empty & Out_Ready;
    // When full, a push only fits if the head leaves on the same edge.
    assign push_ok  = push_req & (~full | pop);

    // Capture state machine. prev_q tracks requests, not acceptances, so a
    // dropped sample is not re-requested on the next edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StArmed;
            prev_q  <= '0;
        end else if (Clear) begin
            state_q <= StArmed;
            prev_q  <= '0;
        end else if (push_req) begin
            state_q <= StRun;
            prev_q  <= Test_Value;
        end
    end

    // FIFO bookkeeping next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (Clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
                default: count_d = count_q;
            endcase
            if (push_req && !push_ok) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (!Clear && push_ok) begin
            mem_q[wr_ptr_q] <= Test_Value;
        end
    end

    assign Out_Valid = ~empty;
    assign Out_Data  = empty ? '0 : mem_q[rd_ptr_q];
    assign Count     = count_q;
    assign Overflow  = overflow_q;

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] stamp_q;
    logic [15:0] stamp_mem_q [DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stamp_q <= '0;
        end else if (Clear) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Clear && push_ok) begin
            stamp_mem_q[wr_ptr_q] <= stamp_q;
        end
    end

    assign Out_Stamp = empty ? '0 : stamp_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_test_value_tracer.sv
// Directed bench for test_value_tracer: reset state, change detection,
// ordered drain, overflow, full push-with-pop wrap-around, Clear and
// asynchronous mid-stream reset.

module tb_test_value_tracer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] Test_Value;
    logic        Capture_En;
    logic        Clear;
    logic [15:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [4:0]  Count;
    logic        Overflow;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] Out_Stamp;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    test_value_tracer dut (
        .CLK        (CLK),
        .RST        (RST),
        .Test_Value (Test_Value),
        .Capture_En (Capture_En),
        .Clear      (Clear),
        .Out_Data   (Out_Data),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Count      (Count),
        .Overflow   (Overflow)
`ifdef TRACE_TIMESTAMP_EN
        ,
        .Out_Stamp  (Out_Stamp)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, land 1 ns after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int unsigned rx[$];
    int unsigned model[$];

    initial begin
        RST        = 1'b1;
        Test_Value = 16'h0000;
        Capture_En = 1'b0;
        Clear      = 1'b0;
        Out_Ready  = 1'b0;
        #1;
        check_eq("rst_count", 32'(Count), 32'd0);
        check_eq("rst_valid", 32'(Out_Valid), 32'd0);
        check_eq("rst_data", 32'(Out_Data), 32'd0);
        check_eq("rst_ovf", 32'(Overflow), 32'd0);

        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;

        // Held value is captured exactly once.
        Capture_En = 1'b1;
        Test_Value = 16'h0005;
        tick();
        check_eq("hold_valid1", 32'(Out_Valid), 32'd1);
        check_eq("hold_count1", 32'(Count), 32'd1);
        check_eq("hold_data1", 32'(Out_Data), 32'h5);
        repeat (9) tick();
        check_eq("hold_count10", 32'(Count), 32'd1);
        Out_Ready = 1'b1;
        tick();
        check_eq("hold_drained", 32'(Count), 32'd0);
        check_eq("hold_valid0", 32'(Out_Valid), 32'd0);

        // Change detection with a consumer always ready.
        begin
            logic [15:0] seq [6];
            seq = '{16'h1, 16'h1, 16'h2, 16'h3, 16'h3, 16'h1};
            for (int i = 0; i < 8; i++) begin
                if (i < 6) Test_Value = seq[i];
                tick();
                if (Out_Valid) rx.push_back(32'(Out_Data));
            end
        end
        check_eq("seq_len", 32'(rx.size()), 32'd4);
        if (rx.size() == 4) begin
            check_eq("seq0", rx[0], 32'h1);
            check_eq("seq1", rx[1], 32'h2);
            check_eq("seq2", rx[2], 32'h3);
            check_eq("seq3", rx[3], 32'h1);
        end
        check_eq("seq_count", 32'(Count), 32'd0);
        check_eq("seq_ovf", 32'(Overflow), 32'd0);

        // Overflow: 17 distinct values into a 16-deep FIFO.
        Out_Ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            Test_Value = 16'(16'h10 + i);
            tick();
            if (i == 15) check_eq("ovf_pre", 32'(Overflow), 32'd0);
        end
        check_eq("ovf_count", 32'(Count), 32'd16);
        check_eq("ovf_flag", 32'(Overflow), 32'd1);
        Capture_En = 1'b0;
        Out_Ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("ovf_drain", 32'(Out_Data), 32'(16'h10 + i));
            tick();
        end
        check_eq("ovf_empty", 32'(Count), 32'd0);
        check_eq("ovf_sticky", 32'(Overflow), 32'd1);
        Out_Ready = 1'b0;
        Clear     = 1'b1;
        tick();
        Clear = 1'b0;
        check_eq("clr_ovf", 32'(Overflow), 32'd0);

        // Full FIFO, push with simultaneous pop, wrap-around order.
        Capture_En = 1'b1;
        for (int i = 0; i < 16; i++) begin
            Test_Value = 16'(16'h100 + i);
            model.push_back(32'(16'h100 + i));
            tick();
        end
        check_eq("full_count", 32'(Count), 32'd16);
        Out_Ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            Test_Value = 16'(16'h200 + i);
            check_eq("wrap_head", 32'(Out_Data), model[0]);
            tick();
            void'(model.pop_front());
            model.push_back(32'(16'h200 + i));
            if (i == 0) check_eq("wrap_count", 32'(Count), 32'd16);
        end
        check_eq("wrap_count_end", 32'(Count), 32'd16);
        check_eq("wrap_ovf", 32'(Overflow), 32'd0);
        Capture_En = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_eq("wrap_drain", 32'(Out_Data), model[i]);
            tick();
        end
        check_eq("wrap_empty", 32'(Count), 32'd0);

        // Clear with 5 entries held and Overflow set.
        Out_Ready  = 1'b0;
        Capture_En = 1'b1;
        for (int i = 0; i < 17; i++) begin
            Test_Value = 16'(16'h300 + i);
            tick();
        end
        Capture_En = 1'b0;
        Out_Ready  = 1'b1;
        repeat (11) tick();
        Out_Ready = 1'b0;
        check_eq("pre_clr_count", 32'(Count), 32'd5);
        check_eq("pre_clr_ovf", 32'(Overflow), 32'd1);
        Capture_En = 1'b1;
        Clear      = 1'b1;
        Test_Value = 16'h0400;
        tick();
        check_eq("clr_count", 32'(Count), 32'd0);
        check_eq("clr_valid", 32'(Out_Valid), 32'd0);
        check_eq("clr_ovf2", 32'(Overflow), 32'd0);
        check_eq("clr_data", 32'(Out_Data), 32'd0);
        Clear = 1'b0;
        tick();
        check_eq("rearm_count", 32'(Count), 32'd1);
        check_eq("rearm_data", 32'(Out_Data), 32'h400);

        // Asynchronous reset pulse between edges.
        Test_Value = 16'h0500;
        tick();
        Test_Value = 16'h0501;
        tick();
        check_eq("pre_rst_count", 32'(Count), 32'd3);
        #2 RST = 1'b1;
        #1;
        check_eq("async_valid", 32'(Out_Valid), 32'd0);
        check_eq("async_count", 32'(Count), 32'd0);
        #2 RST = 1'b0;
        tick();
        check_eq("post_rst_count", 32'(Count), 32'd1);
        check_eq("post_rst_data", 32'(Out_Data), 32'h501);
`ifdef TRACE_TIMESTAMP_EN
        check_eq("post_rst_stamp", 32'(Out_Stamp), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/test_value_tracer.md
Name: test_value_tracer

Overview:
- Downstream observer for the MIPS core's 16-bit Test_Value output.
- Records every change of Test_Value into a small first-word-fall-through trace FIFO.
- A debug host or bench drains the FIFO through a valid/ready interface.
- Allows the whole program result sequence to be checked without probing the core.

Parameters:
DATA_W, 16, width of traced value (matches Test_Value)
DEPTH, 16, FIFO entries; power of two, >= 2
ADDR_W, 4, log2(DEPTH)

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  asynchronous, active-high reset
Test_Value  input  DATA_W  value from MIPS core, sampled every rising edge
Capture_En  input  1  1 = tracing active; 0 = no pushes
Clear  input  1  synchronous flush: empty FIFO, clear Overflow, re-arm
Out_Data  output  DATA_W  head-of-FIFO entry, valid when Out_Valid=1
Out_Valid  output  1  FIFO non-empty
Out_Ready  input  1  consumer accepts head when Out_Valid & Out_Ready at rising edge
Count  output  ADDR_W+1  entries held, 0..DEPTH
Overflow  output  1  sticky: a capture was dropped because FIFO full

Behaviour:
- Reset (async, RST=1):
  - wr_ptr, rd_ptr and Count = 0; Out_Valid = 0; Out_Data = 0; Overflow = 0.
  - prev_q = 0; state = ARMED.
  - Deassertion takes effect at the next rising edge.
- State machine:
  - ARMED: on the first edge with Capture_En=1, push Test_Value unconditionally, load prev_q, go to RUN.
  - RUN: on each edge with Capture_En=1 and Test_Value != prev_q, push Test_Value and load prev_q.
  - Capture_En=0 in either state: no push, prev_q held, state held.
  - Clear=1: go to ARMED on that edge.
- Push request = (ARMED & Capture_En) | (RUN & Capture_En & Test_Value != prev_q).
- Pop = Out_Valid & Out_Ready.
- Latency: a value sampled at edge k is visible on Out_Data with Out_Valid=1 after edge k when the FIFO was empty (one edge).
- Out_Data is the entry at rd_ptr. It stays stable while Out_Valid=1 and no pop occurs. It is 0 when empty.
- Pointers are ADDR_W bits and wrap modulo DEPTH. Count tracks occupancy: +1 on push only, -1 on pop only, unchanged on both.
- Full (Count=DEPTH):
  - Push with simultaneous pop is accepted. Count stays DEPTH.
  - Push without pop drops the sample. Overflow is set and stays set until Clear or RST. prev_q is still updated, so the same value is not re-requested.
- Empty (Count=0): Out_Ready is ignored; no pop and no pointer move.
  - Push while empty with Out_Ready=1 is not bypassed. The value appears next cycle.
- Clear has priority over push and pop on the same edge:
  - pointers and Count = 0, Overflow = 0, state = ARMED, prev_q = 0.
  - The simultaneous sample is discarded.
- Width: Test_Value and the stored entries are DATA_W; no truncation or extension. Count is ADDR_W+1 bits so it can hold DEPTH.
- Reset mid-operation: all contents are discarded immediately. Out_Valid falls asynchronously with RST.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN, defined:
  - Adds a free-running 16-bit cycle counter: reset to 0, +1 every edge, wraps 0xFFFF->0x0000, reset to 0 by Clear.
  - Adds output Out_Stamp[15:0], the counter value at the edge its entry was pushed. It travels with Out_Data through the FIFO.
- Macro undefined: no counter, no Out_Stamp port, storage holds data only.

Test Plan:
- Reset, Capture_En=1, Test_Value held 0x0005 for 10 cycles -> exactly one entry 0x0005. Count=1, Out_Valid=1 after first edge.
- Test_Value sequence 0x0001,0x0001,0x0002,0x0003,0x0003,0x0001 with Out_Ready=1 -> consumer receives 0x0001,0x0002,0x0003,0x0001 in order. Count returns to 0, Overflow=0.
- Out_Ready=0, 17 distinct values 0x0010..0x0020 -> Count=16, Overflow=1. Drained data is 0x0010..0x001F; 0x0020 is lost.
- FIFO full, distinct value pushed with Out_Ready=1 on the same edge -> Count stays 16, Overflow stays 0, new value at tail. Wrap-around order preserved over 40 pushes.
- 5 entries held, Overflow=1, Clear=1 for one edge with a new Test_Value -> Count=0, Out_Valid=0, Overflow=0. Next edge with Capture_En=1 captures the current value even if unchanged.
- Mid-stream RST pulse of 3 ns between edges -> Out_Valid and Count drop to 0 immediately. After release, the first capture behaves as ARMED. With TRACE_TIMESTAMP_EN, the first Out_Stamp equals the cycles since release.
